// File: rtl/da_frame_sink_if.sv
// Result stream leaving da_frame_sink (valid/ready).
// m_tag exists only when DA_FRAME_SINK_TAG_EN is defined.
interface da_frame_sink_if #(
  parameter int DATA_W = 17
);
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
`ifdef DA_FRAME_SINK_TAG_EN
  logic [7:0]        m_tag;
`endif

  modport master (
    output m_data,
    output m_valid,
`ifdef DA_FRAME_SINK_TAG_EN
    output m_tag,
`endif
    input  m_ready
  );

  modport slave (
    input  m_data,
    input  m_valid,
`ifdef DA_FRAME_SINK_TAG_EN
    input  m_tag,
`endif
    output m_ready
  );
endinterface

// File: rtl/da_frame_sink.sv
// Frame-aligned capture of dafir results into a small stream FIFO.
// Optional per-word frame tag: define DA_FRAME_SINK_TAG_EN.
module da_frame_sink #(
  parameter int DATA_W      = 17,
  parameter int FRAME_LEN   = 8,
  parameter int CAP_PHASE   = 7,
  parameter int SKIP_FRAMES = 2,
  parameter int DEPTH       = 4
) (
  input  logic              clk_bit,
  input  logic              rst_n,
  input  logic              frame_sync,
  input  logic [DATA_W-1:0] opy,
  da_frame_sink_if.master   m,
  output logic              ovf,
  input  logic              ovf_clr,
  output logic              armed
);
  localparam int CW =
    (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int SW =
    (SKIP_FRAMES > 0) ? $clog2(SKIP_FRAMES + 1) : 1;
  localparam int AW = $clog2(DEPTH);
  localparam int NW = AW + 1;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    RUN
  } state_t;

  state_t            state;
  logic [CW-1:0]     bit_cnt;
  logic [SW-1:0]     skip_cnt;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [NW-1:0]     count;
  logic [NW-1:0]     count_nxt;

  logic at_cap;
  logic cap;
  logic run_cap;
  logic full;
  logic pop;
  logic push_ok;
  logic ovf_set;

  assign at_cap  = bit_cnt == CW'(CAP_PHASE);
  assign cap     = (state != IDLE) && at_cap
                   && !frame_sync;
  assign run_cap = cap && (state == RUN);
  assign full    = count == NW'(DEPTH);
  assign pop     = m.m_valid && m.m_ready;
  // a pop frees the slot the same-cycle push needs
  assign push_ok = run_cap && (!full || pop);
  assign ovf_set = run_cap && full && !pop;

  always_ff @(posedge clk_bit or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      skip_cnt <= SW'(SKIP_FRAMES);
      armed    <= 1'b0;
    end else if (frame_sync) begin
      state    <= (SKIP_FRAMES == 0) ? RUN : FILL;
      bit_cnt  <= CW'(1);
      skip_cnt <= SW'(SKIP_FRAMES);
      armed    <= 1'b1;
    end else if (state != IDLE) begin
      if (bit_cnt == CW'(FRAME_LEN - 1))
        bit_cnt <= '0;
      else
        bit_cnt <= bit_cnt + CW'(1);
      if (cap && state == FILL) begin
        skip_cnt <= skip_cnt - SW'(1);
        if (skip_cnt == SW'(1))
          state <= RUN;
      end
    end
  end

  always_comb begin
    count_nxt = count;
    if (push_ok && !pop)
      count_nxt = count + NW'(1);
    else if (!push_ok && pop)
      count_nxt = count - NW'(1);
  end

  always_ff @(posedge clk_bit or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      m.m_valid <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= opy;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      count     <= count_nxt;
      m.m_valid <= count_nxt != '0;
      if (ovf_set)
        ovf <= 1'b1;
      else if (ovf_clr)
        ovf <= 1'b0;
    end
  end

  assign m.m_data = m.m_valid ? mem[rd_ptr] : '0;

`ifdef DA_FRAME_SINK_TAG_EN
  logic [7:0] tag_cnt;
  logic [7:0] tag_mem [DEPTH];

  // counts every RUN capture, so dropped words leave a gap
  always_ff @(posedge clk_bit or negedge rst_n) begin
    if (!rst_n) begin
      tag_cnt <= '0;
      for (int i = 0; i < DEPTH; i++)
        tag_mem[i] <= '0;
    end else begin
      if (frame_sync)
        tag_cnt <= '0;
      else if (run_cap)
        tag_cnt <= tag_cnt + 8'd1;
      if (push_ok)
        tag_mem[wr_ptr] <= tag_cnt;
    end
  end

  assign m.m_tag = m.m_valid ? tag_mem[rd_ptr] : '0;
`endif

endmodule

// File: tb/tb_da_frame_sink.sv
// Randomized bench for da_frame_sink against a
// frame-counting queue model.
module tb_da_frame_sink;
  localparam int DW    = 17;
  localparam int FL    = 8;
  localparam int CAP   = 7;
  localparam int SKIP  = 2;
  localparam int DEPTH = 4;

  logic          clk_bit = 1'b0;
  logic          rst_n = 1'b0;
  logic          frame_sync = 1'b0;
  logic          ovf_clr = 1'b0;
  logic [DW-1:0] opy = '0;
  logic          ovf;
  logic          armed;

  da_frame_sink_if #(.DATA_W(DW)) s ();

  da_frame_sink #(
    .DATA_W(DW),
    .FRAME_LEN(FL),
    .CAP_PHASE(CAP),
    .SKIP_FRAMES(SKIP),
    .DEPTH(DEPTH)
  ) dut (
    .clk_bit(clk_bit),
    .rst_n(rst_n),
    .frame_sync(frame_sync),
    .opy(opy),
    .m(s.master),
    .ovf(ovf),
    .ovf_clr(ovf_clr),
    .armed(armed)
  );

  always #5 clk_bit = ~clk_bit;

  int n_chk = 0;
  int n_pass = 0;

  // model: cycles since sync, captures since sync
  bit            ma;
  bit            mo;
  int            since;
  int            caps;
  logic [DW-1:0] qd [$];
  logic [7:0]    qt [$];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
  endtask

  task automatic model_reset();
    ma = 0;
    mo = 0;
    since = 0;
    caps = 0;
    qd.delete();
    qt.delete();
  endtask

  task automatic check_all();
    chk("valid", 32'(s.m_valid),
        32'(qd.size() != 0));
    chk("data", 32'(s.m_data),
        qd.size() != 0 ? 32'(qd[0]) : 32'd0);
    chk("armed", 32'(armed), 32'(ma));
    chk("ovf", 32'(ovf), 32'(mo));
`ifdef DA_FRAME_SINK_TAG_EN
    chk("tag", 32'(s.m_tag),
        qd.size() != 0 ? 32'(qt[0]) : 32'd0);
`endif
  endtask

  task automatic model_edge();
    bit pop;
    bit cap;
    bit set;
    pop = (qd.size() != 0) && s.m_ready;
    cap = ma && !frame_sync && (since % FL) == CAP;
    set = 0;
    if (pop) begin
      void'(qd.pop_front());
      void'(qt.pop_front());
    end
    if (cap) begin
      if (caps >= SKIP) begin
        if (qd.size() == DEPTH)
          set = 1;
        else begin
          qd.push_back(opy);
          qt.push_back(8'((caps - SKIP) % 256));
        end
      end
      caps++;
    end
    if (set)
      mo = 1;
    else if (ovf_clr)
      mo = 0;
    if (frame_sync) begin
      ma = 1;
      since = 1;
      caps = 0;
    end else if (ma)
      since++;
  endtask

  task automatic step(input bit fs,
                      input logic [DW-1:0] d,
                      input bit rdy,
                      input bit clr);
    frame_sync = fs;
    opy = d;
    s.m_ready = rdy;
    ovf_clr = clr;
    @(posedge clk_bit);
    model_edge();
    @(negedge clk_bit);
    check_all();
  endtask

  initial begin
    logic [DW-1:0] d;
    s.m_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk_bit);
    check_all();
    rst_n = 1'b1;

    // unarmed: nothing may be captured
    repeat (100)
      step(0, DW'($urandom), 1'($urandom), 0);

    // first frames are pipeline fill
    step(1, DW'($urandom), 1, 0);
    for (int i = 1; i < 30; i++) begin
      d = DW'($urandom);
      if (i == 7) d = 17'h00010;
      if (i == 15) d = 17'h1FFF4;
      if (i == 23) d = 17'h00036;
      step(0, d, 1, 0);
      if (i == 23) begin
        chk("first_valid", 32'(s.m_valid), 32'd1);
        chk("first_data", 32'(s.m_data), 32'h36);
      end
    end

    // stalled sink: fill and overflow
    repeat (48) step(0, DW'($urandom), 0, 0);
    chk("ovf_set", 32'(ovf), 32'd1);
    step(0, DW'($urandom), 0, 1);
    chk("ovf_clr", 32'(ovf), 32'd0);

    // pop exactly on capture while full
    for (int i = 0; i < 8; i++)
      step(0, DW'($urandom), (since % FL) == CAP, 0);
    chk("full_swap_ovf", 32'(ovf), 32'd0);

    // sync coinciding with capture phase
    repeat (16) step(0, DW'($urandom), 1'($urandom), 0);
    for (int i = 0; i < 16 && (since % FL) != CAP; i++)
      step(0, DW'($urandom), 1, 0);
    step(1, DW'($urandom), 1, 0);
    repeat (24) step(0, DW'($urandom), 1, 0);

    // reset with words queued
    for (int i = 0; i < 100 && qd.size() < 3; i++)
      step(0, DW'($urandom), 0, 0);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_valid", 32'(s.m_valid), 32'd0);
    chk("rst_armed", 32'(armed), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    model_reset();
    @(negedge clk_bit);
    rst_n = 1'b1;
    check_all();
    repeat (30) step(0, DW'($urandom), 1, 0);

    // random traffic
    for (int i = 0; i < 400; i++)
      step($urandom % 40 == 0, DW'($urandom),
           $urandom % 3 == 0, $urandom % 25 == 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
